// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: initiator side of the CPU data-memory port.
// Takes byte/half/word loads and stores from execute and drives a word-addressed,
// byte-masked dmem port. Accesses that cross a word boundary become two back-to-back
// transactions. Read data arrives one cycle after each mem_req cycle.
//
// Ports:
//   i_clk, i_rst (sync, active high), i_clk_en (global hold when low)
//   i_op_valid/i_op_we/i_op_size/i_op_signed/i_op_addr/i_op_wdata : operation request
//   o_busy      : op in flight; accept = i_op_valid && !o_busy && i_clk_en
//   o_ld_valid  : one-cycle pulse (stretched while i_clk_en is low), o_ld_data valid
//   o_ld_data   : aligned, extended load result, held until the next load completes
//   o_mem_req, o_mem_we, o_mask, o_data_addr, o_data_out : dmem request side
//   i_data_in   : dmem read data
module lsu_dmem_master #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_op_valid,
  input  logic              i_op_we,
  input  logic [1:0]        i_op_size,
  input  logic              i_op_signed,
  input  logic [ADDR_W-1:0] i_op_addr,
  input  logic [31:0]       i_op_wdata,
  output logic              o_busy,
  output logic              o_ld_valid,
  output logic [31:0]       o_ld_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [3:0]        o_mask,
  output logic [ADDR_W-3:0] o_data_addr,
  output logic [31:0]       o_data_out,
  input  logic [31:0]       i_data_in
);

  typedef enum logic [1:0] {StIdle, StReq0, StReq1, StResp} state_e;

  localparam logic [ADDR_W-3:0] WaddrOne = {{(ADDR_W-3){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [ADDR_W-3:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_split;
  logic [31:0]       r_lo;
  logic [31:0]       r_ld_data;
  logic              r_ld_valid;

  logic              w_op_split;
  logic [31:0]       w_wdata_rot;
  logic [3:0]        w_mask_base;
  logic [7:0]        w_mask8;
  logic [63:0]       w_pair;
  logic [31:0]       w_shifted;
  logic [31:0]       w_ld_result;

  // Split when the access spills past byte lane 3; size 3 behaves as word.
  always_comb begin
    w_op_split = 1'b0;
    unique case (i_op_size)
      2'd0:    w_op_split = 1'b0;
      2'd1:    w_op_split = (i_op_addr[1:0] == 2'd3);
      default: w_op_split = (i_op_addr[1:0] != 2'd0);
    endcase
  end

  // Store data rotated so byte k of the operand lands in lane (o + k) mod 4.
  always_comb begin
    w_wdata_rot = i_op_wdata;
    unique case (i_op_addr[1:0])
      2'd0: w_wdata_rot = i_op_wdata;
      2'd1: w_wdata_rot = {i_op_wdata[23:0], i_op_wdata[31:24]};
      2'd2: w_wdata_rot = {i_op_wdata[15:0], i_op_wdata[31:16]};
      2'd3: w_wdata_rot = {i_op_wdata[7:0],  i_op_wdata[31:8]};
    endcase
  end

  // Low nibble of the shifted mask is the first access, overflow nibble the second.
  always_comb begin
    w_mask_base = 4'b1111;
    unique case (r_size)
      2'd0:    w_mask_base = 4'b0001;
      2'd1:    w_mask_base = 4'b0011;
      default: w_mask_base = 4'b1111;
    endcase
    w_mask8 = {4'b0000, w_mask_base} << r_off;
  end

  always_comb begin
    w_pair    = r_split ? {i_data_in, r_lo} : {32'b0, i_data_in};
    w_shifted = 32'(w_pair >> {r_off, 3'b000});
    unique case (r_size)
      2'd0:    w_ld_result = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_ld_result = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ld_result = w_shifted;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mask      = 4'b0000;
    o_data_addr = r_waddr;
    case (r_state)
      StIdle: begin
        if (i_op_valid) w_state_nxt = StReq0;
      end
      StReq0: begin
        o_mask    = w_mask8[3:0];
        o_mem_we  = r_we;
        o_mem_req = !r_we;
        if (r_split)   w_state_nxt = StReq1;
        else if (r_we) w_state_nxt = StIdle;
        else           w_state_nxt = StResp;
      end
      StReq1: begin
        o_data_addr = r_waddr + WaddrOne;
        o_mask      = w_mask8[7:4];
        o_mem_we    = r_we;
        o_mem_req   = !r_we;
        w_state_nxt = r_we ? StIdle : StResp;
      end
      StResp: begin
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_off      <= 2'd0;
      r_waddr    <= '0;
      r_wdata    <= 32'b0;
      r_split    <= 1'b0;
      r_lo       <= 32'b0;
      r_ld_data  <= 32'b0;
      r_ld_valid <= 1'b0;
    end else if (i_clk_en) begin
      r_state    <= w_state_nxt;
      r_ld_valid <= (r_state == StResp);
      if (r_state == StIdle && i_op_valid) begin
        r_we     <= i_op_we;
        r_size   <= i_op_size;
        r_signed <= i_op_signed;
        r_off    <= i_op_addr[1:0];
        r_waddr  <= i_op_addr[ADDR_W-1:2];
        r_wdata  <= w_wdata_rot;
        r_split  <= w_op_split;
      end
      // data_in here is the reply to the REQ0 read.
      if (r_state == StReq1 && !r_we) r_lo <= i_data_in;
      if (r_state == StResp) r_ld_data <= w_ld_result;
    end
  end

  assign o_busy     = (r_state != StIdle);
  assign o_ld_valid = r_ld_valid;
  assign o_ld_data  = r_ld_data;
  assign o_data_out = r_wdata;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Randomised bench for lsu_dmem_master: a byte-array reference model predicts load
// results, latency and transaction count; a word memory serves the dmem port.
module tb_lsu_dmem_master;

  typedef struct {
    bit          we;
    logic [3:0]  mask;
    logic [29:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst, clk_en, op_valid, op_we, op_signed;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic        busy, ld_valid, mem_req, mem_we;
  logic [31:0] ld_data, data_out;
  logic [3:0]  mask;
  logic [29:0] data_addr;
  logic [31:0] rdata = 32'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int bad_cnt  = 0;

  logic [31:0] mem     [64]  = '{default: '0};
  logic [7:0]  ref_mem [256] = '{default: '0};
  txn_t        txq[$];

  lsu_dmem_master #(.ADDR_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_op_valid  (op_valid),
    .i_op_we     (op_we),
    .i_op_size   (op_size),
    .i_op_signed (op_signed),
    .i_op_addr   (op_addr),
    .i_op_wdata  (op_wdata),
    .o_busy      (busy),
    .o_ld_valid  (ld_valid),
    .o_ld_data   (ld_data),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mask      (mask),
    .o_data_addr (data_addr),
    .o_data_out  (data_out),
    .i_data_in   (rdata)
  );

  always #5 clk = ~clk;

  // dmem: shares the global clock enable, registered read, byte-masked write.
  always @(posedge clk) begin
    if (clk_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mask[i]) mem[data_addr[5:0]][8*i +: 8] <= data_out[8*i +: 8];
      end
      if (mem_req) rdata <= mem[data_addr[5:0]];
      if (mem_we || mem_req)
        txq.push_back('{we: mem_we, mask: mask, addr: data_addr, data: data_out});
      if ((mem_we && mem_req) || (data_addr[29:6] != 24'b0)) bad_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input bit sg);
    int          n;
    logic [31:0] v;
    n = nbytes(sz);
    v = 32'b0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(a + k) & 255];
    if (sg && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // Issue one op from idle and wait for completion; freeze_at > 0 drops clk_en for
  // three cycles once that many edges (counting the accept edge) have passed.
  task automatic run_op(input bit we, input logic [1:0] sz, input bit sg, input int a,
                        input logic [31:0] wd, input bit junk, input int freeze_at,
                        output logic [31:0] ld);
    int          n, edges, exp_edges;
    bit          split;
    logic [31:0] exp_ld;
    logic [7:0]  s_ctl;
    logic [29:0] s_addr;
    n         = nbytes(sz);
    split     = ((a % 4) + n) > 4;
    exp_edges = we ? (split ? 3 : 2) : (split ? 4 : 3);
    exp_ld    = model_load(a, sz, sg);
    txq.delete();
    op_we = we; op_size = sz; op_signed = sg; op_addr = 32'(a); op_wdata = wd;
    op_valid = 1'b1;
    @(posedge clk); edges = 1; #1;
    if (junk) begin
      op_we = 1'b1; op_size = 2'($urandom_range(0, 3));
      op_addr = 32'($urandom_range(0, 255)); op_wdata = $urandom;
    end else begin
      op_valid = 1'b0;
    end
    while (edges < 20 && (we ? busy : !ld_valid)) begin
      @(posedge clk); edges++; #1;
      if (edges == freeze_at) begin
        clk_en = 1'b0;
        s_ctl  = {busy, ld_valid, mem_req, mem_we, mask};
        s_addr = data_addr;
        repeat (3) begin
          @(posedge clk); #1;
          check_eq("frz_ctl", {24'b0, busy, ld_valid, mem_req, mem_we, mask}, {24'b0, s_ctl});
          check_eq("frz_addr", {2'b0, data_addr}, {2'b0, s_addr});
        end
        clk_en = 1'b1;
      end
    end
    op_valid = 1'b0;
    check_eq("latency", edges, exp_edges);
    check_eq("txn_count", txq.size(), split ? 2 : 1);
    foreach (txq[i]) check_eq("txn_we", {31'b0, txq[i].we}, {31'b0, we});
    ld = ld_data;
    if (!we) check_eq("ld_data", ld_data, exp_ld);
    else for (int k = 0; k < n; k++) ref_mem[(a + k) & 255] = wd[8*k +: 8];
  endtask

  initial begin
    logic [31:0] ld;
    rst = 1'b1; clk_en = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_size = 2'd0;
    op_signed = 1'b0; op_addr = 32'b0; op_wdata = 32'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_ctl", {24'b0, busy, ld_valid, mem_req, mem_we, mask}, 32'b0);
    check_eq("rst_addr", {2'b0, data_addr}, 32'b0);
    check_eq("rst_dout", data_out, 32'b0);
    check_eq("rst_ld", ld_data, 32'b0);

    // 1: word store / load
    run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 0, ld);
    check_eq("t1_mask", {28'b0, txq[0].mask}, 32'hF);
    check_eq("t1_addr", {2'b0, txq[0].addr}, 32'd4);
    run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 0, ld);
    check_eq("t1_ld", ld, 32'hDEADBEEF);

    // 2: byte store, signed and unsigned reload
    run_op(1'b1, 2'd0, 1'b0, 32'h21, 32'h80, 1'b0, 0, ld);
    check_eq("t2_mask", {28'b0, txq[0].mask}, 32'h2);
    check_eq("t2_lane1", {24'b0, txq[0].data[15:8]}, 32'h80);
    run_op(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1'b0, 0, ld);
    check_eq("t2_lds", ld, 32'hFFFFFF80);
    run_op(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1'b0, 0, ld);
    check_eq("t2_ldu", ld, 32'h00000080);

    // 3: split half store at 0x13
    run_op(1'b1, 2'd1, 1'b0, 32'h13, 32'h1234, 1'b0, 0, ld);
    check_eq("t3_w1", {txq[0].addr, txq[0].mask, txq[0].data[31:24]}, {30'd4, 4'h8, 8'h34});
    check_eq("t3_w2", {txq[1].addr, txq[1].mask, txq[1].data[7:0]}, {30'd5, 4'h1, 8'h12});
    run_op(1'b0, 2'd1, 1'b1, 32'h13, 32'h0, 1'b0, 0, ld);
    check_eq("t3_ld", ld, 32'h00001234);

    // 4: split word load at 0x05
    run_op(1'b1, 2'd2, 1'b0, 32'h04, 32'h44332211, 1'b0, 0, ld);
    run_op(1'b1, 2'd2, 1'b0, 32'h08, 32'h88776655, 1'b0, 0, ld);
    run_op(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 1'b0, 0, ld);
    check_eq("t4_reqs", {txq[0].addr[15:0], txq[1].addr[15:0]}, {16'd1, 16'd2});
    check_eq("t4_ld", ld, 32'h55443322);

    // 5: reset in REQ0 of a split word store at 0x07
    txq.delete();
    op_we = 1'b1; op_size = 2'd2; op_addr = 32'h07; op_wdata = 32'hA1B2C3D4; op_valid = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0;
    check_eq("t5_req0", {22'b0, mem_we, mask, 5'b0, data_addr[0]}, {22'b0, 1'b1, 4'h8, 5'b0, 1'b1});
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_eq("t5_ctl", {24'b0, busy, ld_valid, mem_req, mem_we, mask}, 32'b0);
    check_eq("t5_addr", {2'b0, data_addr}, 32'b0);
    check_eq("t5_dout", data_out, 32'b0);
    check_eq("t5_ld", ld_data, 32'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_txns", txq.size(), 1);
    check_eq("t5_mem1", mem[1], 32'hD4332211);
    check_eq("t5_mem2", mem[2], 32'h88776655);
    ref_mem[7] = 8'hD4;

    // 6: junk ops while busy, clk_en dropped in REQ1, stretched ld_valid
    run_op(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 1'b1, 2, ld);
    check_eq("t6_ld", ld, 32'h55D43322);
    clk_en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("t6_ldv_hold", {31'b0, ld_valid}, 32'd1);
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_ldv_drop", {31'b0, ld_valid}, 32'd0);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 240)), $urandom, 1'($urandom_range(0, 1)), 0, ld);
    end

    for (int w = 0; w < 64; w++)
      check_eq("mem_word", mem[w],
               {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
    check_eq("bus_protocol", bad_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
Initiator side of the CPU data-memory port.
- Accepts byte, halfword and word load/store operations from the execute stage.
- Drives the word-addressed, byte-masked dmem interface: mem_req, mem_we, mask, data_addr, data_out.
- Consumes the 1-cycle-latency registered read data on data_in, then aligns and sign/zero-extends it.
- Splits accesses that cross a word boundary into two back-to-back memory transactions.

Parameters:
- ADDR_W, 32, CPU byte-address width; data_addr is ADDR_W-2 bits wide.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  when low, all internal state and registered outputs hold.
- op_valid  in  1  operation request.
- op_we  in  1  1 = store, 0 = load.
- op_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- op_signed  in  1  load sign-extend enable; ignored for stores.
- op_addr  in  ADDR_W  byte address.
- op_wdata  in  32  store data, right-justified.
- busy  out  1  high while an operation is in flight; an op is accepted only when op_valid && !busy && clk_en.
- ld_valid  out  1  one-cycle pulse; ld_data is valid.
- ld_data  out  32  aligned, extended load result.
- mem_req  out  1  read request to dmem.
- mem_we  out  1  write enable to dmem.
- mask  out  4  byte-lane enables; lane i = data bits 8i+7:8i.
- data_addr  out  ADDR_W-2  word address.
- data_out  out  32  lane-aligned write data.
- data_in  in  32  dmem read data; valid the cycle after a mem_req cycle.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - busy, ld_valid, mem_req, mem_we, mask, data_addr, data_out, ld_data all reset to 0.
  - Reset mid-operation aborts it. An unissued second half of a split store is never written.
- Captured fields: o = op_addr[1:0], w = op_addr[ADDR_W-1:2].
- Split condition: (half && o == 3) || (word && o != 0).
- Little-endian lane mapping:
  - byte mask = 1<<o.
  - half mask = 0011<<o.
  - word mask = 1111<<o.
  - Each mask is truncated to 4 bits for the first access.
  - The second access uses the overflowed bits: half o=3 gives 0001; word gives 1111>>(4-o).
- data_out = op_wdata rotated left by 8*o. The same value is driven on both accesses of a split.
- FSM states: IDLE, REQ0, REQ1, RESP.
  - IDLE: busy=0. On accept, capture op fields and go to REQ0.
  - REQ0: drive data_addr=w and the first mask. Store: mem_we=1. Load: mem_req=1. Next state: REQ1 if split; RESP if unsplit load; IDLE if unsplit store.
  - REQ1: drive data_addr=w+1 (wraps modulo 2^(ADDR_W-2)) and the second mask, with mem_we or mem_req as for REQ0. Load: capture data_in (the first word) into lo_reg. Next state: RESP for a load, IDLE for a store.
  - RESP (loads only): form {data_in, lo_reg} for a split or {32'b0, data_in} otherwise. Shift right by 8*o. Take the low 8/16/32 bits and sign-extend (op_signed) or zero-extend. Register the result into ld_data and go to IDLE.
- ld_valid is high for exactly one cycle after leaving RESP (the first IDLE cycle). ld_data holds its value until the next load completes.
- mem_req, mem_we and mask are 0 in IDLE and RESP. mem_req and mem_we are never both high.
- Latency, counting edges after the accept edge:
  - Unsplit load: ld_valid after 3 edges.
  - Split load: ld_valid after 4 edges.
  - Unsplit store: busy low after 2 edges.
  - Split store: busy low after 3 edges.
- A new op may be accepted in the same cycle that ld_valid is high.
- clk_en low:
  - FSM and outputs freeze, including an ld_valid pulse, which is extended.
  - A frozen REQ state repeats an identical access; this is idempotent.
- op_valid while busy is ignored and is not queued.

Test Plan:
1. Store word 0xDEADBEEF at 0x10, then load word at 0x10.
   -> Store: one cycle of mem_we=1, mask=1111, data_addr=4.
   -> Load: ld_data=0xDEADBEEF, ld_valid exactly 3 edges after accept.
2. Byte store 0x80 at 0x21, then load it with op_signed=1 and again with op_signed=0.
   -> Store: mask=0010, data_out[15:8]=0x80.
   -> Loads: ld_data=0xFFFFFF80, then 0x00000080.
3. Half store 0x1234 at 0x13.
   -> Write 1: data_addr=4, mask=1000, lane 3 = 0x34.
   -> Write 2: data_addr=5, mask=0001, lane 0 = 0x12.
   -> Signed half load from 0x13 returns 0x00001234, ld_valid 4 edges after accept.
4. Word load at 0x05, with memory word 1 = 0x44332211 and word 2 = 0x88776655.
   -> Two mem_req cycles (addr 1, then addr 2).
   -> ld_data=0x55443322.
5. Assert rst in the REQ0 cycle of a split word store at 0x07.
   -> Only the addr-1 write (mask 1000) occurs; word 2 is unchanged.
   -> All outputs are 0 the cycle after reset.
6. Hold op_valid high with new ops while busy, and drop clk_en for 3 cycles during REQ1.
   -> Extra ops are ignored.
   -> FSM state and outputs are frozen while clk_en is low.
   -> Final ld_data is the same as with clk_en held high.
